// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter / line-refill sequencer.
package mem_arb_pkg;

  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;
  typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} state_e;

  localparam int TRD_W          = 3;
  localparam int LINE_WORDS_DEF = 4;

  function automatic int idx_width(input int line_words);
    return $clog2(line_words);
  endfunction

  // Clear the word-index and byte-offset bits of a miss address.
  function automatic logic [31:0] line_align(input logic [31:0] a, input int iw);
    return a & ~((32'd1 << (iw + 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker; remembers which side completed last.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic req_d,
  input  logic upd,
  input  logic upd_owner,
  output logic gnt_d
);

  owner_e last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (upd) last_d = owner_e'(upd_owner);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= OWN_I;
    else        last_q <= last_d;
  end

  assign gnt_d = req_d & (~req_i | (last_q == OWN_I));

endmodule

// File: rtl/mem_arb.sv
// I/D miss arbiter and line-refill sequencer for the shared memory port.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int LINE_WORDS     = LINE_WORDS_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_req,
  input  logic [31:0]                      i_addr,
  input  logic [TRD_W-1:0]                 i_trd,
  input  logic                             i_abort,
  input  logic                             d_req,
  input  logic [31:0]                      d_addr,
  input  logic [TRD_W-1:0]                 d_trd,
  input  logic                             d_abort,
  output logic                             mem_req,
  output logic [31:0]                      mem_addr,
  input  logic                             mem_gnt,
  input  logic                             mem_rvalid,
  input  logic [31:0]                      mem_rdata,
  output logic                             fill_i,
  output logic                             fill_d,
  output logic [idx_width(LINE_WORDS)-1:0] fill_idx,
  output logic [31:0]                      fill_data,
  output logic                             i_done,
  output logic                             d_done,
  output logic [TRD_W-1:0]                 done_trd,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int IDX_W = idx_width(LINE_WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LINE_WORDS - 1);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d, nxt_owner;
  logic [TRD_W-1:0]   trd_q, trd_d, done_trd_q;
  logic [31:0]        addr_q, addr_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               aborted_q, aborted_d;
  logic               mem_req_q, busy_q, i_done_q, d_done_q;
  logic               i_act, d_act, own_abort, other_act, take, rr_gnt_d, beat, fill_ok;

  assign i_act     = i_req & ~i_abort;
  assign d_act     = d_req & ~d_abort;
  assign own_abort = (owner_q == OWN_I) ? (i_abort | ~i_req) : (d_abort | ~d_req);
  assign other_act = (owner_q == OWN_I) ? d_act : i_act;

  mem_arb_rr u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (i_act),
    .req_d     (d_act),
    .upd       (state_q == DONE),
    .upd_owner (owner_q),
    .gnt_d     (rr_gnt_d)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            terr_q, terr_d, wd_fire;

  // Any memory-side progress restarts the watchdog.
  always_comb begin
    wd_d    = '0;
    wd_fire = 1'b0;
    if ((state_q == REQ || state_q == BURST) && !(mem_gnt || mem_rvalid)) begin
      wd_d    = wd_q + 1'b1;
      wd_fire = (wd_d == WD_W'(TIMEOUT_CYCLES));
    end
    terr_d = terr_q | wd_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    trd_d     = trd_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    nxt_owner = OWN_I;
    take      = 1'b0;
    unique case (state_q)
      IDLE: if (i_act || d_act) begin
        take      = 1'b1;
        nxt_owner = owner_e'(rr_gnt_d);
      end
      REQ: begin
        // A grant in the abort cycle still commits us to draining the line.
        if (mem_gnt) begin
          state_d   = BURST;
          cnt_d     = '0;
          aborted_d = own_abort;
        end else if (own_abort) begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (own_abort) aborted_d = 1'b1;
        if (mem_rvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = (aborted_q || own_abort) ? IDLE : DONE;
        end
      end
      DONE: begin
        // The side just completed sits out this cycle; only the other may chain.
        state_d = IDLE;
        if (other_act) begin
          take      = 1'b1;
          nxt_owner = (owner_q == OWN_I) ? OWN_D : OWN_I;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d = REQ;
      owner_d = nxt_owner;
      trd_d   = (nxt_owner == OWN_I) ? i_trd : d_trd;
      addr_d  = line_align((nxt_owner == OWN_I) ? i_addr : d_addr, IDX_W);
    end
`ifdef MEM_ARB_TIMEOUT_EN
    if (wd_fire) state_d = IDLE;
`endif
    if (state_d == IDLE) aborted_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      trd_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      aborted_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      done_trd_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      trd_q      <= trd_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      aborted_q  <= aborted_d;
      mem_req_q  <= (state_d == REQ);
      busy_q     <= (state_d != IDLE);
      i_done_q   <= (state_d == DONE) && (owner_d == OWN_I);
      d_done_q   <= (state_d == DONE) && (owner_d == OWN_D);
      done_trd_q <= (state_d == DONE) ? trd_d : '0;
    end
  end

  assign beat    = (state_q == BURST) && mem_rvalid;
  assign fill_ok = beat && !aborted_q && !own_abort;

  assign mem_req   = mem_req_q;
  assign mem_addr  = addr_q;
  assign busy      = busy_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign done_trd  = done_trd_q;
  assign fill_i    = fill_ok && (owner_q == OWN_I);
  assign fill_d    = fill_ok && (owner_q == OWN_D);
  assign fill_idx  = beat ? cnt_q : '0;
  assign fill_data = beat ? mem_rdata : '0;

endmodule
